fdiv: RTL and testbench
=======================

FDIV -- requirements
Module: fdiv

Interface
REQ-001 The block SHALL have parameter FINV_WAIT, default 3, which is the number of cycles the divisor is held on the reciprocal unit before its result is sampled (legal range 2..15).
REQ-002 The block SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rstn, input, width 1: reset, asynchronous, active-low.
REQ-004 The block SHALL have port in_valid, input, width 1: the operand pair is valid.
REQ-005 The block SHALL have port in_ready, output, width 1: the block accepts operands.
REQ-006 The block SHALL have port x1, input, width 32: the dividend, IEEE-754 single precision.
REQ-007 The block SHALL have port x2, input, width 32: the divisor, IEEE-754 single precision.
REQ-008 The block SHALL have port out_valid, output, width 1: y holds the quotient.
REQ-009 The block SHALL have port out_ready, input, width 1: the consumer takes y.
REQ-010 The block SHALL have port y, output, width 32: the quotient x1/x2, single precision.

Function
REQ-011 The block SHALL compute y = x1 * finv(x2) by driving a finv instance (ports clk, s, d) with the captured divisor on s.
REQ-012 The block SHALL implement the states IDLE, INV_WAIT, MUL and HOLD, with a 2-bit state register.
REQ-013 In IDLE the block SHALL drive in_ready=1; on in_valid&&in_ready it SHALL capture x1 and x2 into internal registers, load a 4-bit counter with FINV_WAIT-1, and move to INV_WAIT.
REQ-014 In INV_WAIT the block SHALL hold the captured divisor constant on finv.s and decrement the counter; at counter==0 it SHALL register finv.d as the reciprocal and move to MUL.
REQ-015 In MUL the block SHALL register the product of x1 and the reciprocal into y in one cycle and move to HOLD.
REQ-016 In HOLD the block SHALL drive out_valid=1 with y stable; on out_ready=1 it SHALL move to IDLE at the next edge.
REQ-017 in_ready SHALL be 1 only in IDLE; there is no overlap of operations; an accept and an output handshake never occur in the same cycle.
REQ-018 Latency SHALL be FINV_WAIT+2 rising edges from the accept edge to out_valid=1 (5 edges at the default).
REQ-019 The multiply SHALL be as follows:
- sign = x1[31] xor recip[31]
- exponent = e1 + er - 127, computed at 10 bits signed
- mantissa: 24x24 -> 48-bit product; normalize by 1 if bit 47 is set (exponent +1)
- rounding: round-to-nearest-even using guard, round and sticky (OR of the remaining bits); on mantissa round carry-out, exponent +1
REQ-020 The multiply SHALL handle the following boundaries:
- final exponent > 254: y = {sign, 8'hFF, 23'h0}
- final exponent < 1: y = {sign, 31'h0}; denormals flushed
REQ-021 The block SHALL apply these special operands, which override the datapath result with the state sequence unchanged:
- x1 exponent 0: y = {sign, 31'h0}
- x2 exponent 0: y = {sign, 8'hFF, 23'h0}
- x1 or x2 exponent 255: y = 32'h7FC00000
REQ-022 While out_valid=1 and out_ready=0, y and out_valid SHALL hold indefinitely; in_valid is ignored.
REQ-023 out_valid SHALL never be asserted outside HOLD.

Reset
REQ-024 rstn=0 SHALL asynchronously force the following:
- state = IDLE
- counter = 0
- captured operands = 0
- y = 32'h0
- out_valid = 0
- in_ready = 1 (IDLE)
REQ-025 Reset asserted mid-operation (INV_WAIT, MUL or HOLD) SHALL abort the operation and emit no output for it; the first accept after release starts clean.
REQ-026 The finv instance SHALL receive clk only; its internal pipeline content after reset is don't-care because the counter guarantees FINV_WAIT fresh cycles.

Verification
REQ-027 The bench SHALL apply x1=0x3F800000, x2=0x40000000, out_ready=1 and SHALL require y=0x3F000000 with out_valid at edge 5 after accept.
REQ-028 The bench SHALL apply x1=0x40C00000, x2=0x40400000 and SHALL require y within 1 ulp of 0x40000000; it SHALL also sweep 10k random normal pairs against a reference model within 2 ulp.
REQ-029 The bench SHALL apply x1=0xBF800000, x2=0x00000000 and SHALL require y=0xFF800000; with x1=0x00000000, x2=0x40400000 it SHALL require y=0x00000000.
REQ-030 The bench SHALL hold out_ready=0 for 6 cycles in HOLD and SHALL require y constant, out_valid=1, in_ready=0 with in_valid=1 ignored; after out_ready=1, in_ready=1 on the next cycle.
REQ-031 The bench SHALL pulse rstn low in INV_WAIT and SHALL require out_valid=0, y=0, in_ready=1 immediately; a following op 0x40400000/0x3F800000 SHALL give 0x40400000.
REQ-032 The bench SHALL issue back-to-back ops with in_valid held high and SHALL require exactly one accept per IDLE visit and an output sequence in accept order.

Source files
------------

// File: rtl/fdiv.sv
// Single-precision divider: y = x1 * finv(x2), with one operation in flight at a time.
// Also holds the registered reciprocal unit and a small handshake checker.

module finv (
  input  logic        clk,
  input  logic [31:0] s,
  output logic [31:0] d
);

  localparam logic [49:0] ONE_SHL49 = 50'h2000000000000;

  logic [31:0] d_q;

  // Reciprocal of a normal single: 2^49 / mantissa gives 26 quotient bits, rounded to nearest-even.
  function automatic logic [31:0] recip_f(input logic [31:0] v);
    logic [7:0]  e;
    logic [23:0] m;
    logic [25:0] q;
    logic [23:0] rem;
    logic        rnd;
    logic [24:0] mr;
    logic [22:0] frac;
    logic [9:0]  eb;
    logic [31:0] r;
    e    = v[30:23];
    m    = {1'b1, v[22:0]};
    q    = 26'(ONE_SHL49 / {26'd0, m});
    rem  = 24'(ONE_SHL49 % {26'd0, m});
    rnd  = q[1] & (q[0] | (rem != 24'd0) | q[2]);
    mr   = {1'b0, q[25:2]} + {24'd0, rnd};
    frac = mr[24] ? mr[23:1] : mr[22:0];
    eb   = 10'd253 - {2'b00, e} + {9'd0, mr[24]};
    if (e == 8'hFF) begin
      r = 32'h7FC00000;
    end else if (e == 8'h00) begin
      r = {v[31], 8'hFF, 23'h0};
    end else if (v[22:0] == 23'h0) begin
      // Exact powers of two: the quotient would overflow 26 bits, so build 2^-k directly.
      if (e == 8'hFE) begin
        r = {v[31], 31'h0};
      end else begin
        r = {v[31], 8'd254 - e, 23'h0};
      end
    end else if ($signed(eb) < 10'sd1) begin
      r = {v[31], 31'h0};
    end else begin
      r = {v[31], eb[7:0], frac};
    end
    return r;
  endfunction

  // Single register stage on the reciprocal.
  always_ff @(posedge clk) begin
    d_q <= recip_f(s);
  end

  assign d = d_q;

endmodule

module fdiv_checker (
  input logic        clk,
  input logic        rstn,
  input logic        in_ready,
  input logic        out_valid,
  input logic        out_ready,
  input logic [31:0] y
);

  logic        stall_q;
  logic [31:0] y_prev_q;

  // Remember whether the previous cycle was a stalled output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q  <= 1'b0;
      y_prev_q <= 32'h0;
    end else begin
      stall_q  <= out_valid && !out_ready;
      y_prev_q <= y;
    end
  end

  // Accept and output are exclusive; a stalled result stays put.
  always_ff @(posedge clk) begin
    if (rstn) begin
      a_excl: assert (!(out_valid && in_ready));
      if (stall_q) begin
        a_hold: assert (out_valid && (y == y_prev_q));
      end
    end
  end

endmodule

module fdiv #(
  parameter int FINV_WAIT = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INV_WAIT = 2'd1,
    MUL      = 2'd2,
    HOLD     = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(FINV_WAIT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] x1_q, x1_d;
  logic [31:0] x2_q, x2_d;
  logic [31:0] recip_q, recip_d;
  logic [31:0] y_q, y_d;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [31:0] finv_d;

  // a * r for normal operands, round-to-nearest-even, overflow to inf and underflow flushed to zero.
  function automatic logic [31:0] fmul_f(input logic [31:0] a, input logic [31:0] r);
    logic               sign;
    logic [23:0]        ma;
    logic [23:0]        mb;
    logic [47:0]        p;
    logic signed [9:0]  ex;
    logic [23:0]        m24;
    logic               g;
    logic               rb;
    logic               st;
    logic               rup;
    logic [24:0]        mr;
    logic [22:0]        frac;
    logic [31:0]        res;
    sign = a[31] ^ r[31];
    ma   = {1'b1, a[22:0]};
    mb   = {1'b1, r[22:0]};
    p    = {24'd0, ma} * {24'd0, mb};
    ex   = $signed({2'b00, a[30:23]}) + $signed({2'b00, r[30:23]}) - 10'sd127;
    if (p[47]) begin
      m24 = p[47:24];
      g   = p[23];
      rb  = p[22];
      st  = |p[21:0];
      ex  = ex + 10'sd1;
    end else begin
      m24 = p[46:23];
      g   = p[22];
      rb  = p[21];
      st  = |p[20:0];
    end
    rup  = g & (rb | st | m24[0]);
    mr   = {1'b0, m24} + {24'd0, rup};
    frac = mr[24] ? mr[23:1] : mr[22:0];
    if (mr[24]) begin
      ex = ex + 10'sd1;
    end else begin
      ex = ex;
    end
    if (r[30:23] == 8'h00) begin
      res = {sign, 31'h0};
    end else if (ex > 10'sd254) begin
      res = {sign, 8'hFF, 23'h0};
    end else if (ex < 10'sd1) begin
      res = {sign, 31'h0};
    end else begin
      res = {sign, ex[7:0], frac};
    end
    return res;
  endfunction

  // Special operands override the datapath; NaN/inf inputs take priority over zeros.
  function automatic logic [31:0] result_f(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] r);
    logic        sign;
    logic [31:0] res;
    sign = a[31] ^ b[31];
    if ((a[30:23] == 8'hFF) || (b[30:23] == 8'hFF)) begin
      res = 32'h7FC00000;
    end else if (a[30:23] == 8'h00) begin
      res = {sign, 31'h0};
    end else if (b[30:23] == 8'h00) begin
      res = {sign, 8'hFF, 23'h0};
    end else begin
      res = fmul_f(a, r);
    end
    return res;
  endfunction

  finv u_finv (
    .clk (clk),
    .s   (x2_q),
    .d   (finv_d)
  );

  fdiv_checker u_chk (
    .clk       (clk),
    .rstn      (rstn),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  // Next-state and datapath capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    recip_d = recip_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x1_d    = x1;
          x2_d    = x2;
          cnt_d   = WAIT_LOAD;
          state_d = INV_WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      INV_WAIT: begin
        if (cnt_q == 4'd0) begin
          recip_d = finv_d;
          state_d = MUL;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          state_d = INV_WAIT;
        end
      end
      MUL: begin
        y_d     = result_f(x1_q, x2_q, recip_q);
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, operand and output registers; handshake flags follow the next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      x1_q        <= 32'h0;
      x2_q        <= 32'h0;
      recip_q     <= 32'h0;
      y_q         <= 32'h0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      recip_q     <= recip_d;
      y_q         <= y_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == HOLD);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;

endmodule

// File: tb/tb_fdiv.sv
// Directed and random checks of fdiv against hand-computed constants and a real-valued model.

module tb_fdiv;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;

  int          n_checks = 0;
  int          n_errors = 0;
  logic        mon_en = 1'b0;
  int          acc_cnt = 0;
  logic [31:0] got_q[$];

  logic [31:0] op_a[4] = '{32'h3F800000, 32'h40C00000, 32'h40400000, 32'hC0C00000};
  logic [31:0] op_b[4] = '{32'h40000000, 32'h40400000, 32'h3F800000, 32'h40400000};
  logic [31:0] op_y[4] = '{32'h3F000000, 32'h40000000, 32'h40400000, 32'hC0000000};

  always #5 clk = ~clk;

  fdiv #(.FINV_WAIT(3)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1        (x1),
    .x2        (x2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp,
                       input int unsigned tol = 0);
    logic [31:0] diff;
    n_checks++;
    diff = (got > exp) ? got - exp : exp - got;
    if ($isunknown(got) || (diff > tol)) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h (tol %0d)", tag, got, exp, tol);
    end
  endtask

  function automatic real sp2r(input logic [31:0] v);
    logic [63:0] b;
    b = {v[31], {3'b000, v[30:23]} + 11'd896, v[22:0], 29'd0};
    return $bitstoreal(b);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] b;
    logic [10:0] ed;
    logic [23:0] m;
    b  = $realtobits(r);
    ed = b[62:52];
    m  = {1'b0, b[51:29]} + {23'd0, b[28]};
    return {b[63], 8'(ed - 11'd896 + {10'd0, m[23]}), (m[23] ? 23'd0 : m[22:0])};
  endfunction

  // One full transaction; edges counts the accept edge as edge 1.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int edges);
    int guard;
    @(negedge clk);
    x1 = a;
    x2 = b;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    edges = 1;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end while (!out_valid && edges < 30);
    res = y;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (in_valid && in_ready) acc_cnt++;
      if (out_valid && out_ready) got_q.push_back(y);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hold_y;
    logic        seen;
    int          e;
    int          guard;

    rstn = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    x1 = 32'h0;
    x2 = 32'h0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    do_op(32'h3F800000, 32'h40000000, r, e);
    check("one_half", r, 32'h3F000000);
    check("latency", 32'(e), 32'd5);
    check("ov_no_ready", in_ready, 0);

    do_op(32'h40C00000, 32'h40400000, r, e);
    check("six_thirds", r, 32'h40000000, 1);
    do_op(32'h40400000, 32'h40400000, r, e);
    check("three_thirds", r, 32'h3F800000);
    do_op(32'hC0C00000, 32'h40400000, r, e);
    check("neg_six_thirds", r, 32'hC0000000);
    do_op(32'hBF800000, 32'h00000000, r, e);
    check("div_by_zero", r, 32'hFF800000);
    do_op(32'h00000000, 32'h40400000, r, e);
    check("zero_dividend", r, 32'h00000000);
    do_op(32'h7F800000, 32'h3F800000, r, e);
    check("inf_nan", r, 32'h7FC00000);
    do_op(32'h7F000000, 32'h3E800000, r, e);
    check("overflow", r, 32'h7F800000);
    do_op(32'h00800000, 32'h40000000, r, e);
    check("underflow", r, 32'h00000000);

    // Output stall with a new request pending.
    @(negedge clk);
    out_ready = 1'b0;
    do_op(32'h40C00000, 32'h3F800000, r, e);
    check("stall_result", r, 32'h40C00000);
    hold_y = r;
    in_valid = 1'b1;
    x1 = 32'h3F800000;
    x2 = 32'h40000000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("stall_y", y, hold_y);
      check("stall_ov", out_valid, 1);
      check("stall_nready", in_ready, 0);
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("release_ready", in_ready, 1);
    check("release_ov", out_valid, 0);

    // Reset while waiting on the reciprocal.
    @(negedge clk);
    x1 = 32'h40C00000;
    x2 = 32'h40400000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("abort_ov", out_valid, 0);
    check("abort_y", y, 32'h0);
    check("abort_ready", in_ready, 1);
    @(negedge clk);
    rstn = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_out", seen, 0);
    do_op(32'h40400000, 32'h3F800000, r, e);
    check("after_abort", r, 32'h40400000);

    // Back-to-back requests with in_valid held high.
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    acc_cnt = 0;
    x1 = op_a[0];
    x2 = op_b[0];
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (!in_ready && guard < 20);
      @(posedge clk);
      #1;
      check("b2b_nready", in_ready, 0);
      if (k < 3) begin
        x1 = op_a[k+1];
        x2 = op_b[k+1];
      end else begin
        in_valid = 1'b0;
      end
    end
    guard = 0;
    while (got_q.size() < 4 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 mon_en = 1'b0;
    check("b2b_accepts", 32'(acc_cnt), 32'd4);
    check("b2b_outputs", 32'(got_q.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check("b2b_order", (k < got_q.size()) ? got_q[k] : 32'hDEADBEEF, op_y[k]);
    end

    // Random normal pairs against the real-valued model.
    for (int n = 0; n < 10000; n++) begin
      a = {1'($urandom_range(1, 0)), 8'($urandom_range(154, 100)), 23'($urandom)};
      b = {1'($urandom_range(1, 0)), 8'($urandom_range(154, 100)), 23'($urandom)};
      do_op(a, b, r, e);
      check("rnd_ov", out_valid, 1);
      check("rnd_quot", r, r2sp(sp2r(a) / sp2r(b)), 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
